bus_master_if: RTL

//   CPU-side initiator for the shared 8-bit external memory bus (addr/data/cs/we/oe) used by ROM, RAM and I/O devices.

---
 rtl/bus_master_if.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/bus_master_if.sv
// CPU-side initiator for the shared 8-bit external memory bus.
// Byte and little-endian word requests become SETUP/STROBE/HOLD bus cycles.
module bus_master_if #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        req_we,
    input  logic        req_word,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic [15:0] rdata,
    output logic        ack,
    output logic        busy,
    output logic [15:0] bus_addr,
    inout  wire  [7:0]  bus_data,
    output logic        bus_cs,
    output logic        bus_we,
    output logic        bus_oe
);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              hi, hi_nx;
    logic              lat_we, lat_we_nx;
    logic              lat_word, lat_word_nx;
    logic [15:0]       lat_wdata, lat_wdata_nx;
    logic [7:0]        lo_byte, lo_byte_nx;
    logic              drive, drive_nx;
    logic [15:0]       rdata_nx, addr_nx;
    logic              ack_nx, busy_nx, cs_nx, we_nx, oe_nx;
    logic [7:0]        wbyte;

    // Byte 0 of a word goes to addr, byte 1 to addr+1
    assign wbyte    = hi ? lat_wdata[15:8] : lat_wdata[7:0];
    assign bus_data = drive ? wbyte : 8'hzz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            hi        <= 1'b0;
            lat_we    <= 1'b0;
            lat_word  <= 1'b0;
            lat_wdata <= '0;
            lo_byte   <= '0;
            drive     <= 1'b0;
            rdata     <= '0;
            bus_addr  <= '0;
            ack       <= 1'b0;
            busy      <= 1'b0;
            bus_cs    <= 1'b0;
            bus_we    <= 1'b0;
            bus_oe    <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            hi        <= hi_nx;
            lat_we    <= lat_we_nx;
            lat_word  <= lat_word_nx;
            lat_wdata <= lat_wdata_nx;
            lo_byte   <= lo_byte_nx;
            drive     <= drive_nx;
            rdata     <= rdata_nx;
            bus_addr  <= addr_nx;
            ack       <= ack_nx;
            busy      <= busy_nx;
            bus_cs    <= cs_nx;
            bus_we    <= we_nx;
            bus_oe    <= oe_nx;
        end
    end

    // Next-state and next-output values; bus pins follow the state being entered
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        hi_nx        = hi;
        lat_we_nx    = lat_we;
        lat_word_nx  = lat_word;
        lat_wdata_nx = lat_wdata;
        lo_byte_nx   = lo_byte;
        drive_nx     = 1'b0;
        rdata_nx     = rdata;
        addr_nx      = bus_addr;
        ack_nx       = 1'b0;
        busy_nx      = busy;
        cs_nx        = 1'b0;
        we_nx        = 1'b0;
        oe_nx        = 1'b0;

        case (state)
            IDLE: begin
                busy_nx = 1'b0;
                if (req) begin
                    lat_we_nx    = req_we;
                    lat_word_nx  = req_word;
                    lat_wdata_nx = req_wdata;
                    addr_nx      = req_addr;
                    hi_nx        = 1'b0;
                    busy_nx      = 1'b1;
                    cs_nx        = 1'b1;
                    state_nx     = SETUP;
                end
            end
            SETUP: begin
                cnt_nx   = CNT_W'(WAIT_CYCLES);
                cs_nx    = 1'b1;
                oe_nx    = !lat_we;
                we_nx    = lat_we;
                drive_nx = lat_we;
                state_nx = STROBE;
            end
            STROBE: begin
                drive_nx = lat_we;
                if (cnt == '0) begin
                    if (!lat_we) begin
                        if (hi) begin
                            rdata_nx = {bus_data, lo_byte};
                        end else if (lat_word) begin
                            lo_byte_nx = bus_data;
                        end else begin
                            rdata_nx = {8'h00, bus_data};
                        end
                    end
                    ack_nx   = !lat_word || hi;
                    state_nx = HOLD;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                    cs_nx  = 1'b1;
                    oe_nx  = !lat_we;
                    we_nx  = lat_we;
                end
            end
            HOLD: begin
                if (lat_word && !hi) begin
                    hi_nx    = 1'b1;
                    addr_nx  = bus_addr + 16'd1;
                    cs_nx    = 1'b1;
                    state_nx = SETUP;
                end else begin
                    busy_nx  = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: begin
                busy_nx  = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end
endmodule
